// File: rtl/lift_sched_ctrl.sv
// lift_sched_ctrl: self-timed SCAN lift scheduler; takes up/dn/car request vectors and obstruct, drives registered floor index/one-hot, direction, motion, door, state and one-hot request-clear pulses
module lift_sched_ctrl #(
  parameter int N_FLOORS = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES = 8,
  parameter int IDX_W = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] i_up_req,
  input  logic [N_FLOORS-1:0] i_dn_req,
  input  logic [N_FLOORS-1:0] i_car_req,
  input  logic                i_door_obstruct,
  output logic [IDX_W-1:0]    o_flr_idx,
  output logic [N_FLOORS-1:0] o_flr_pos,
  output logic                o_direction,
  output logic                o_motion,
  output logic                o_door_open,
  output logic [N_FLOORS-1:0] o_up_clr,
  output logic [N_FLOORS-1:0] o_dn_clr,
  output logic [N_FLOORS-1:0] o_car_clr,
  output logic [1:0]          o_state
);
  localparam int CNT_W = $clog2((TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);
  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] g;
  logic dir_n, arrive, above, below, ahead, behind, svc, hit, open;
  logic [N_FLOORS-1:0] up, dn, car, any_req, above_m, below_m, sel, up_clr_n, dn_clr_n, car_clr_n;
  always_comb begin
    up = i_up_req & ~o_up_clr;
    dn = i_dn_req & ~o_dn_clr;
    car = i_car_req & ~o_car_clr;
    any_req = up | dn | car;
    arrive = state == MOVE && cnt == '0;
    g = arrive ? (o_direction ? o_flr_idx - IDX_W'(1) : o_flr_idx + IDX_W'(1)) : o_flr_idx;
    for (int k = 0; k < N_FLOORS; k++) begin
      above_m[k] = k > int'(g);
      below_m[k] = k < int'(g);
    end
    above = |(any_req & above_m);
    below = |(any_req & below_m);
    ahead = o_direction ? below : above;
    behind = o_direction ? above : below;
    sel = ONE << g;
    svc = |(sel & (car | (o_direction ? dn : up))) | (|(sel & any_req) & !ahead);
    hit = |(sel & (car | (o_direction ? dn : up))) | (|(sel & any_req) & !ahead & !behind);
    open = state == DOOR ? hit : (state == IDLE || arrive) && svc;
    car_clr_n = open ? sel : '0;
    up_clr_n = open && (!o_direction || !(ahead || behind)) ? sel : '0;
    dn_clr_n = open && (o_direction || !(ahead || behind)) ? sel : '0;
    state_n = state;
    cnt_n = cnt;
    dir_n = o_direction;
    if (open) begin
      state_n = DOOR;
      cnt_n = DOOR_LD;
    end else if (state == MOVE && !arrive) begin
      cnt_n = cnt - CNT_W'(1);
    end else if (state == DOOR && i_door_obstruct) begin
      cnt_n = DOOR_LD;
    end else if (state == DOOR && cnt != '0) begin
      cnt_n = cnt - CNT_W'(1);
    end else begin
      state_n = ahead || behind ? MOVE : IDLE;
      dir_n = o_direction ^ (behind && !ahead);
      cnt_n = ahead || behind ? TRAVEL_LD : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      o_flr_idx <= '0;
      o_direction <= 1'b0;
      o_motion <= 1'b0;
      o_door_open <= 1'b0;
      o_flr_pos <= ONE;
      o_up_clr <= '0;
      o_dn_clr <= '0;
      o_car_clr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_flr_idx <= g;
      o_direction <= dir_n;
      o_motion <= state_n == MOVE;
      o_door_open <= state_n == DOOR;
      o_flr_pos <= state_n == MOVE ? '0 : sel;
      o_up_clr <= up_clr_n;
      o_dn_clr <= dn_clr_n;
      o_car_clr <= car_clr_n;
    end
  end
  assign o_state = state;
endmodule

// File: tb/tb_lift_sched_ctrl.sv
// tb_lift_sched_ctrl: scoreboard bench for lift_sched_ctrl (N_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
module tb_lift_sched_ctrl;
  typedef struct packed {
    logic [1:0] st;
    logic [2:0] idx;
    logic [7:0] pos;
    logic dir;
    logic mot;
    logic door;
    logic [7:0] upc;
    logic [7:0] dnc;
    logic [7:0] carc;
  } outs_t;
  typedef struct {
    string nm;
    int at;
    outs_t e;
  } exp_t;
  typedef struct {
    string nm;
    logic [7:0] up;
    logic [7:0] dn;
    logic [7:0] car;
    logic obs;
    outs_t e;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, obs = 1'b0;
  logic [7:0] up_req = '0, dn_req = '0, car_req = '0;
  logic [7:0] pu = '0, pd = '0, pc = '0;
  logic [2:0] flr_idx;
  logic [7:0] flr_pos, up_clr, dn_clr, car_clr;
  logic direction, motion, door_open;
  logic [1:0] state;
  int cyc = 0, n_vec = 0, n_bad = 0, b;
  exp_t sb[$];
  exp_t x;
  outs_t act;
  vec_t vt[11];
  lift_sched_ctrl #(.N_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk),
    .reset(reset),
    .i_up_req(up_req),
    .i_dn_req(dn_req),
    .i_car_req(car_req),
    .i_door_obstruct(obs),
    .o_flr_idx(flr_idx),
    .o_flr_pos(flr_pos),
    .o_direction(direction),
    .o_motion(motion),
    .o_door_open(door_open),
    .o_up_clr(up_clr),
    .o_dn_clr(dn_clr),
    .o_car_clr(car_clr),
    .o_state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic outs_t mk(int st, int idx, logic dir, logic [7:0] upc = 8'h00, logic [7:0] dnc = 8'h00, logic [7:0] carc = 8'h00);
    outs_t o;
    o.st = 2'(st);
    o.idx = 3'(idx);
    o.pos = st == 1 ? 8'h00 : 8'h01 << idx;
    o.dir = dir;
    o.mot = st == 1;
    o.door = st == 2;
    o.upc = upc;
    o.dnc = dnc;
    o.carc = carc;
    return o;
  endfunction
  function automatic vec_t mv(string nm, logic [7:0] u, logic [7:0] d, logic [7:0] c, logic ob, outs_t e);
    vec_t v;
    v.nm = nm;
    v.up = u;
    v.dn = d;
    v.car = c;
    v.obs = ob;
    v.e = e;
    return v;
  endfunction
  function automatic string fmt(outs_t o);
    return $sformatf("st=%0d idx=%0d pos=%h dir=%b mot=%b door=%b clr(up/dn/car)=%h/%h/%h",
      o.st, o.idx, o.pos, o.dir, o.mot, o.door, o.upc, o.dnc, o.carc);
  endfunction
  task automatic push(string nm, int at, outs_t e);
    exp_t y;
    y.nm = nm;
    y.at = at;
    y.e = e;
    sb.push_back(y);
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      up_req = up_req & ~pu;
      dn_req = dn_req & ~pd;
      car_req = car_req & ~pc;
      pu = up_clr;
      pd = dn_clr;
      pc = car_clr;
    end
  endtask
  always @(negedge clk) begin
    act = {state, flr_idx, flr_pos, direction, motion, door_open, up_clr, dn_clr, car_clr};
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      x = sb.pop_front();
      n_vec++;
      if (act !== x.e || x.at != cyc) begin
        n_bad++;
        $display("FAIL %s @cycle %0d: got %s, expected %s", x.nm, cyc, fmt(act), fmt(x.e));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vt[0] = mv("v_car0", 8'h00, 8'h00, 8'h01, 1'b0, mk(2, 0, 0, 8'h01, 8'h01, 8'h01));
    vt[1] = mv("v_up0", 8'h01, 8'h00, 8'h00, 1'b0, mk(2, 0, 0, 8'h01, 8'h01, 8'h01));
    vt[2] = mv("v_dn0", 8'h00, 8'h01, 8'h00, 1'b0, mk(2, 0, 0, 8'h01, 8'h01, 8'h01));
    vt[3] = mv("v_car0_up3", 8'h08, 8'h00, 8'h01, 1'b0, mk(2, 0, 0, 8'h01, 8'h00, 8'h01));
    vt[4] = mv("v_dn0_car5", 8'h00, 8'h01, 8'h20, 1'b0, mk(1, 0, 0));
    vt[5] = mv("v_up7", 8'h80, 8'h00, 8'h00, 1'b0, mk(1, 0, 0));
    vt[6] = mv("v_none", 8'h00, 8'h00, 8'h00, 1'b0, mk(0, 0, 0));
    vt[7] = mv("v_obs_car0", 8'h00, 8'h00, 8'h01, 1'b1, mk(2, 0, 0, 8'h01, 8'h01, 8'h01));
    vt[8] = mv("v_all0_car2", 8'h01, 8'h01, 8'h05, 1'b0, mk(2, 0, 0, 8'h01, 8'h00, 8'h01));
    vt[9] = mv("v_dn7", 8'h00, 8'h80, 8'h00, 1'b0, mk(1, 0, 0));
    vt[10] = mv("v_obs_only", 8'h00, 8'h00, 8'h00, 1'b1, mk(0, 0, 0));
    step(2);
    push("reset", cyc + 1, mk(0, 0, 0));
    step(1);
    for (int i = 0; i < 11; i++) begin
      reset = 1'b1;
      {up_req, dn_req, car_req, obs} = '0;
      step(1);
      reset = 1'b0;
      up_req = vt[i].up;
      dn_req = vt[i].dn;
      car_req = vt[i].car;
      obs = vt[i].obs;
      push(vt[i].nm, cyc + 1, vt[i].e);
      step(1);
    end
    reset = 1'b1;
    {up_req, dn_req, car_req, obs} = '0;
    step(1);
    reset = 1'b0;
    step(1);
    b = cyc;
    car_req = 8'h01;
    push("t1_open", b + 1, mk(2, 0, 0, 8'h01, 8'h01, 8'h01));
    push("t1_masked", b + 2, mk(2, 0, 0));
    push("t1_open3", b + 3, mk(2, 0, 0));
    push("t1_close", b + 4, mk(0, 0, 0));
    step(4);
    step(1);
    b = cyc;
    up_req = 8'h20;
    push("t2_go", b + 1, mk(1, 0, 0));
    push("t2_f0", b + 4, mk(1, 0, 0));
    push("t2_f1", b + 5, mk(1, 1, 0));
    push("t2_f4", b + 20, mk(1, 4, 0));
    push("t2_arr5", b + 21, mk(2, 5, 0, 8'h20, 8'h20, 8'h20));
    push("t2_close", b + 24, mk(0, 5, 0));
    step(24);
    reset = 1'b1;
    {up_req, dn_req, car_req, obs} = '0;
    step(1);
    reset = 1'b0;
    b = cyc;
    car_req = 8'h40;
    dn_req = 8'h10;
    push("t3_pass4", b + 17, mk(1, 4, 0));
    push("t3_arr6", b + 25, mk(2, 6, 0, 8'h40, 8'h00, 8'h40));
    push("t3_rev", b + 28, mk(1, 6, 1));
    push("t3_f5", b + 32, mk(1, 5, 1));
    push("t3_arr4", b + 36, mk(2, 4, 1, 8'h10, 8'h10, 8'h10));
    push("t3_idle", b + 39, mk(0, 4, 1));
    step(39);
    b = cyc;
    car_req = 8'h08;
    push("t4_go", b + 1, mk(1, 4, 1));
    push("t4_arr3", b + 5, mk(2, 3, 1, 8'h08, 8'h08, 8'h08));
    push("t4_obs1", b + 6, mk(2, 3, 1));
    push("t4_obs5", b + 10, mk(2, 3, 1));
    push("t4_last", b + 12, mk(2, 3, 1));
    push("t4_close", b + 13, mk(0, 3, 1));
    step(5);
    obs = 1'b1;
    step(5);
    obs = 1'b0;
    step(3);
    b = cyc;
    car_req = 8'h80;
    push("t5_go", b + 1, mk(1, 3, 0));
    push("t5_arr7", b + 17, mk(2, 7, 0, 8'h80, 8'h80, 8'h80));
    step(17);
    dn_req = 8'h02;
    push("t5_rev", b + 20, mk(1, 7, 1));
    push("t5_f2", b + 43, mk(1, 2, 1));
    push("t5_arr1", b + 44, mk(2, 1, 1, 8'h02, 8'h02, 8'h02));
    push("t5_close", b + 47, mk(0, 1, 1));
    step(30);
    step(1);
    b = cyc;
    car_req = 8'h20;
    push("t6_go", b + 1, mk(1, 1, 0));
    push("t6_f3", b + 9, mk(1, 3, 0));
    push("t6_mid", b + 10, mk(1, 3, 0));
    step(10);
    reset = 1'b1;
    push("t6_reset", b + 11, mk(0, 0, 0));
    step(1);
    reset = 1'b0;
    car_req = 8'h00;
    push("t6_after", b + 12, mk(0, 0, 0));
    step(1);
    n_vec++;
    if (state !== 2'd0 || motion !== 1'b0 || door_open !== 1'b0 || (up_clr | dn_clr | car_clr) !== 8'h00) begin
      n_bad++;
      $display("FAIL t6_direct: st=%0d mot=%b door=%b clr=%h/%h/%h", state, motion, door_open, up_clr, dn_clr, car_clr);
    end
    b = cyc;
    car_req = 8'h01;
    push("t7_open", b + 1, mk(2, 0, 0, 8'h01, 8'h01, 8'h01));
    push("t7_masked", b + 2, mk(2, 0, 0));
    push("t7_reload", b + 3, mk(2, 0, 0, 8'h01, 8'h01, 8'h01));
    push("t7_still", b + 5, mk(2, 0, 0));
    push("t7_close", b + 6, mk(0, 0, 0));
    step(2);
    up_req = 8'h01;
    step(4);
    n_vec++;
    if (door_open !== 1'b0 || flr_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL t7_direct: door=%b idx=%0d", door_open, flr_idx);
    end
    step(2);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never compared, expected %s", x.nm, fmt(x.e));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad != 0) $display("FAIL");
    else $display("PASS");
    $finish;
  end
endmodule
